// File: rtl/dpram_arbiter.sv
// Two-port round-robin arbiter in front of a single-clock dual-port RAM.
// Grants up to two requesters per cycle and steers registered read data back by tag.
module dpram_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int AW    = 6,
  localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      req_we,
  input  logic [N_REQ*AW-1:0]   req_addr,
  input  logic [N_REQ*DW-1:0]   req_wdata,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      rvalid,
  output logic [N_REQ*DW-1:0]   rdata,
  output logic [DW-1:0]         ram_data_a,
  output logic [DW-1:0]         ram_data_b,
  output logic [AW-1:0]         ram_addr_a,
  output logic [AW-1:0]         ram_addr_b,
  output logic                  ram_we_a,
  output logic                  ram_we_b,
  input  logic [DW-1:0]         ram_q_a,
  input  logic [DW-1:0]         ram_q_b,
  output logic [PW-1:0]         dbg_ptr
);

  logic [PW-1:0]       ptr;
  logic [PW-1:0]       ptr_next;
  logic [PW-1:0]       last;
  logic [PW-1:0]       w0;
  logic [PW-1:0]       w1;
  logic [PW-1:0]       cand;
  logic                found0;
  logic                found1;
  logic                conflict;
  logic                grant_a;
  logic                grant_b;
  logic [AW-1:0]       addr0;
  logic [AW-1:0]       addr1;
  logic [DW-1:0]       wdata0;
  logic [DW-1:0]       wdata1;
  logic                we0;
  logic                we1;
  int                  idx;

  logic                tag_a_v;
  logic                tag_b_v;
  logic [PW-1:0]       tag_a_idx;
  logic [PW-1:0]       tag_b_idx;
  logic [N_REQ*DW-1:0] rdata_q;

  // Rotating scan from ptr: first active requester is W0, second is W1.
  always_comb begin
    found0 = 1'b0;
    found1 = 1'b0;
    w0     = '0;
    w1     = '0;
    idx    = 0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = PW'(idx);
      if (req[cand]) begin
        if (!found0) begin
          found0 = 1'b1;
          w0     = cand;
        end else if (!found1) begin
          found1 = 1'b1;
          w1     = cand;
        end
      end
    end
  end

  assign addr0  = req_addr[w0*AW +: AW];
  assign addr1  = req_addr[w1*AW +: AW];
  assign wdata0 = req_wdata[w0*DW +: DW];
  assign wdata1 = req_wdata[w1*DW +: DW];
  assign we0    = req_we[w0];
  assign we1    = req_we[w1];

  // Same-location access involving a write would race inside the RAM; B backs off.
  assign conflict = found1 && (addr0 == addr1) && (we0 || we1);
  assign grant_a  = found0 && !rst;
  assign grant_b  = found1 && !conflict && !rst;

  always_comb begin
    gnt = '0;
    if (grant_a) gnt[w0] = 1'b1;
    if (grant_b) gnt[w1] = 1'b1;
  end

  assign ram_we_a   = grant_a & we0;
  assign ram_addr_a = grant_a ? addr0  : '0;
  assign ram_data_a = grant_a ? wdata0 : '0;
  assign ram_we_b   = grant_b & we1;
  assign ram_addr_b = grant_b ? addr1  : '0;
  assign ram_data_b = grant_b ? wdata1 : '0;

  always_comb begin
    last = grant_b ? w1 : w0;
    if (last == PW'(N_REQ - 1)) ptr_next = '0;
    else                        ptr_next = last + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      tag_a_v   <= 1'b0;
      tag_b_v   <= 1'b0;
      tag_a_idx <= '0;
      tag_b_idx <= '0;
      rdata_q   <= '0;
    end else begin
      if (grant_a) ptr <= ptr_next;
      tag_a_v   <= grant_a & ~we0;
      tag_a_idx <= w0;
      tag_b_v   <= grant_b & ~we1;
      tag_b_idx <= w1;
      if (tag_a_v) rdata_q[tag_a_idx*DW +: DW] <= ram_q_a;
      if (tag_b_v) rdata_q[tag_b_idx*DW +: DW] <= ram_q_b;
    end
  end

  // The RAM output is already registered, so the tagged slot passes it straight
  // through for the response cycle and rdata_q holds it afterwards.
  always_comb begin
    rvalid = '0;
    rdata  = rdata_q;
    if (tag_a_v) begin
      rvalid[tag_a_idx]           = 1'b1;
      rdata[tag_a_idx*DW +: DW]   = ram_q_a;
    end
    if (tag_b_v) begin
      rvalid[tag_b_idx]           = 1'b1;
      rdata[tag_b_idx*DW +: DW]   = ram_q_b;
    end
  end

  assign dbg_ptr = ptr;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: directed scenarios then held-request random traffic,
// checked against a queue-based arbitration model and an array memory model.
module tb_dpram_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [N*DW-1:0] rdata;
  logic [DW-1:0]   ram_data_a, ram_data_b;
  logic [AW-1:0]   ram_addr_a, ram_addr_b;
  logic            ram_we_a, ram_we_b;
  logic [DW-1:0]   ram_q_a, ram_q_b;
  logic [1:0]      dbg_ptr;
  logic            mem_clear;

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  dpram_arbiter #(.N_REQ(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_q_a(ram_q_a), .ram_q_b(ram_q_b), .dbg_ptr(dbg_ptr)
  );

  // Behavioural dual-port RAM with registered outputs.
  logic [DW-1:0] ram_mem [64];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= '0;
    end else begin
      if (ram_we_a) ram_mem[ram_addr_a] <= ram_data_a;
      if (ram_we_b) ram_mem[ram_addr_b] <= ram_data_b;
    end
    ram_q_a <= ram_mem[ram_addr_a];
    ram_q_b <= ram_mem[ram_addr_b];
  end

  // reference model state
  int            m_ptr;
  logic [DW-1:0] m_mem [64];
  logic [N-1:0]  exp_rvalid;
  logic [DW-1:0] exp_rdata [N];
  logic [N-1:0]  last_gnt;
  logic [N-1:0]  obs_gnt, obs_rvalid;
  logic [N*DW-1:0] obs_rdata;
  logic [AW-1:0] obs_addr_a, obs_addr_b;
  logic          obs_we_b;
  logic [1:0]    obs_ptr;

  function automatic logic [AW-1:0] a_of(int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] d_of(int i);
    return req_wdata[i*DW +: DW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requesters in round-robin order from the pointer; first two are candidates.
  task automatic model_arb(output logic [N-1:0] eg, output int e0, output int e1);
    int ord[$];
    for (int k = 0; k < N; k++)
      if (req[(m_ptr + k) % N]) ord.push_back((m_ptr + k) % N);
    eg = '0; e0 = -1; e1 = -1;
    if (ord.size() > 0) begin
      e0 = ord[0];
      eg[e0] = 1'b1;
    end
    if (ord.size() > 1) begin
      if (!(a_of(ord[0]) == a_of(ord[1]) && (req_we[ord[0]] || req_we[ord[1]]))) begin
        e1 = ord[1];
        eg[e1] = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    exp_rvalid = '0;
    for (int i = 0; i < N; i++) exp_rdata[i] = '0;
  endtask

  // driver tasks
  task automatic set_req(int i, int we, int addr, int data);
    req[i] = 1'b1;
    req_we[i] = we[0];
    req_addr[i*AW +: AW] = AW'(addr);
    req_wdata[i*DW +: DW] = DW'(data);
  endtask

  task automatic clear_reqs();
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
  endtask

  // One cycle: check at negedge against the model, then advance the model at posedge.
  task automatic step();
    logic [N-1:0]    eg;
    logic [N-1:0]    new_rv;
    logic [N*DW-1:0] pack;
    int e0, e1;
    @(negedge clk);
    if (rst) begin
      model_reset();
      eg = '0; e0 = -1; e1 = -1;
    end else begin
      model_arb(eg, e0, e1);
    end
    for (int i = 0; i < N; i++) pack[i*DW +: DW] = exp_rdata[i];
    obs_gnt = gnt; obs_rvalid = rvalid; obs_rdata = rdata;
    obs_addr_a = ram_addr_a; obs_addr_b = ram_addr_b; obs_we_b = ram_we_b; obs_ptr = dbg_ptr;
    chk("gnt",    gnt,        eg);
    chk("we_a",   ram_we_a,   (e0 >= 0) ? req_we[e0] : 1'b0);
    chk("addr_a", ram_addr_a, (e0 >= 0) ? a_of(e0) : '0);
    chk("data_a", ram_data_a, (e0 >= 0) ? d_of(e0) : '0);
    chk("we_b",   ram_we_b,   (e1 >= 0) ? req_we[e1] : 1'b0);
    chk("addr_b", ram_addr_b, (e1 >= 0) ? a_of(e1) : '0);
    chk("data_b", ram_data_b, (e1 >= 0) ? d_of(e1) : '0);
    chk("rvalid", rvalid,     exp_rvalid);
    chk("rdata",  rdata,      pack);
    chk("ptr",    dbg_ptr,    m_ptr[1:0]);
    @(posedge clk);
    last_gnt = eg;
    new_rv = '0;
    if (!rst) begin
      if (e0 >= 0 && !req_we[e0]) begin new_rv[e0] = 1'b1; exp_rdata[e0] = m_mem[a_of(e0)]; end
      if (e1 >= 0 && !req_we[e1]) begin new_rv[e1] = 1'b1; exp_rdata[e1] = m_mem[a_of(e1)]; end
      if (e0 >= 0 && req_we[e0]) m_mem[a_of(e0)] = d_of(e0);
      if (e1 >= 0 && req_we[e1]) m_mem[a_of(e1)] = d_of(e1);
      if (e0 >= 0) m_ptr = (((e1 >= 0) ? e1 : e0) + 1) % N;
    end
    exp_rvalid = new_rv;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    model_reset();
    last_gnt = '0;
    clear_reqs();
    rst = 1'b1;
    mem_clear = 1'b1;

    // reset then idle
    step(); step();
    chk("rst_gnt", obs_gnt, 4'b0000);
    chk("rst_rvalid", obs_rvalid, 4'b0000);
    rst = 1'b0;
    mem_clear = 1'b0;
    step();

    // dual write, then cross read
    set_req(0, 1, 'h01, 'h33);
    set_req(1, 1, 'h02, 'h44);
    step();
    chk("dual_gnt", obs_gnt, 4'b0011);
    chk("dual_addr_a", obs_addr_a, 6'h01);
    chk("dual_addr_b", obs_addr_b, 6'h02);
    clear_reqs();
    set_req(2, 0, 'h01, 0);
    set_req(3, 0, 'h02, 0);
    step();
    chk("cross_gnt", obs_gnt, 4'b1100);
    clear_reqs();
    step();
    chk("cross_rvalid", obs_rvalid, 4'b1100);
    chk("cross_rdata2", obs_rdata[23:16], 8'h33);
    chk("cross_rdata3", obs_rdata[31:24], 8'h44);

    // address conflict: write wins port A, read waits a cycle
    set_req(0, 1, 'h03, 'h55);
    set_req(1, 0, 'h03, 0);
    step();
    chk("conf_gnt", obs_gnt, 4'b0001);
    chk("conf_we_b", obs_we_b, 1'b0);
    chk("conf_addr_b", obs_addr_b, 6'h00);
    req[0] = 1'b0;
    step();
    chk("conf_gnt2", obs_gnt, 4'b0010);
    clear_reqs();
    step();
    chk("conf_rvalid", obs_rvalid, 4'b0010);
    chk("conf_rdata1", obs_rdata[15:8], 8'h55);

    // bring pointer back to 0, then all four read constantly
    set_req(3, 0, 'h05, 0);
    step();
    clear_reqs();
    for (int i = 0; i < N; i++) set_req(i, 0, i, 0);
    step(); chk("rr_gnt0", obs_gnt, 4'b0011);
    step(); chk("rr_gnt1", obs_gnt, 4'b1100); chk("rr_rv1", obs_rvalid, 4'b0011);
    step(); chk("rr_gnt2", obs_gnt, 4'b0011); chk("rr_rv2", obs_rvalid, 4'b1100);
    step(); chk("rr_gnt3", obs_gnt, 4'b1100); chk("rr_rv3", obs_rvalid, 4'b0011);
    clear_reqs();
    step();

    // wrap-around: ptr=3 with req3 and req0 active
    set_req(2, 0, 'h06, 0);
    step();
    clear_reqs();
    set_req(3, 0, 'h07, 0);
    set_req(0, 0, 'h08, 0);
    step();
    chk("wrap_ptr_before", obs_ptr, 2'd3);
    chk("wrap_gnt", obs_gnt, 4'b1001);
    chk("wrap_addr_a", obs_addr_a, 6'h07);
    chk("wrap_addr_b", obs_addr_b, 6'h08);
    clear_reqs();
    step();
    chk("wrap_ptr_after", obs_ptr, 2'd1);

    // reset mid-read: grant req2 then assert rst before its response
    set_req(2, 0, 'h01, 0);
    step();
    clear_reqs();
    rst = 1'b1;
    step();
    chk("midrst_rvalid", obs_rvalid, 4'b0000);
    chk("midrst_rdata", obs_rdata, '0);
    rst = 1'b0;
    step();
    chk("post_rvalid", obs_rvalid, 4'b0000);
    chk("post_ptr", obs_ptr, 2'd0);

    // random held-request traffic over a small address range to provoke conflicts
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] || last_gnt[i]) begin
          if ($urandom_range(0, 99) < 65)
            set_req(i, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255));
          else
            req[i] = 1'b0;
        end
      end
      step();
    end
    clear_reqs();
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dpram_arbiter.md
Name: dpram_arbiter

Overview:
- Shares one Dual_port_ram (8-bit data, 6-bit address, ports A and B, single clock) among N_REQ requesters.
- Each cycle, grants up to two requests in round-robin order. The first winner drives port A and the second drives port B.
- Routes registered read data back to the requester that issued the read.
- Sits between client blocks and the RAM instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 8, data width; must match the RAM.
- AW, 6, address width; must match the RAM.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester request, held until granted.
- req_we  in  N_REQ  per-requester write enable: 1 = write, 0 = read.
- req_addr  in  N_REQ*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- req_wdata  in  N_REQ*DW  flattened write data.
- gnt  out  N_REQ  combinational grant; a request completes in any cycle where req[i] & gnt[i].
- rvalid  out  N_REQ  registered; read data valid for requester i.
- rdata  out  N_REQ*DW  registered flattened read data.
- ram_data_a, ram_data_b  out  DW  RAM write data.
- ram_addr_a, ram_addr_b  out  AW  RAM addresses.
- ram_we_a, ram_we_b  out  1  RAM write enables.
- ram_q_a, ram_q_b  in  DW  RAM read data, registered inside the RAM, valid one cycle after address.

Behaviour:
- Reset values (applied asynchronously while rst=1):
  - ptr=0; rvalid=0; rdata=0; tag registers cleared.
  - gnt=0 and ram_we_a=ram_we_b=0 while rst=1.
  - ram_addr_*=0 and ram_data_*=0.
- Arbitration (combinational):
  - Scan requesters starting at ptr, wrapping modulo N_REQ.
  - First active requester = winner W0, mapped to port A.
  - Next active requester = candidate W1, mapped to port B.
- Conflict rule:
  - If W1 addresses the same location as W0 and either one is a write, W1 is not granted this cycle and port B stays idle.
  - Two reads to the same address are both granted.
- Idle port: we=0, addr=0, data=0.
- Pointer update on each clock where at least one grant occurs: ptr <= (index of last granted requester + 1) mod N_REQ. Otherwise ptr holds.
- Fairness: a continuously asserted request is granted within N_REQ cycles.
- Write: RAM write occurs at the granting clock edge. No response is returned.
- Read:
  - At the granting edge, register per-port tags {valid, requester index}.
  - Next cycle, rvalid[idx] = 1 for exactly one cycle and rdata[idx] = ram_q of that port.
  - Other requesters' rdata hold their previous values.
  - Read latency is 1 cycle after grant.
  - Back-to-back reads by the same requester yield consecutive rvalid pulses.
- Wrap-around: scanning wraps past N_REQ-1 to 0. The pointer wraps likewise.
- Simultaneous events: a requester cannot receive both ports in one cycle; W1 is always a different index than W0.
- Single requester: only port A is used.
- Reset mid-operation:
  - In-flight read tags are discarded and no rvalid is produced after reset releases.
  - A write granted in the same cycle rst asserts is not guaranteed.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all req=0 → gnt=0, rvalid=0, ram_we_a=ram_we_b=0, ptr=0.
- Dual write, then cross read: cycle 1: req0 write 8'h33 @6'h01, req1 write 8'h44 @6'h02 → gnt=4'b0011, port A @01, port B @02. Cycle 2: req2 reads @01, req3 reads @02. Cycle 3 → rvalid[2] with rdata=8'h33, rvalid[3] with rdata=8'h44.
- Address conflict: req0 write 8'h55 @6'h03 and req1 read @6'h03 in the same cycle → gnt=4'b0001, port B idle. Next cycle → req1 granted, and one cycle later rdata[1]=8'h55.
- Round-robin fairness: all 4 requesters reading constantly → grants 0011, 1100, 0011, 1100; each requester gets one rvalid every 2 cycles.
- Wrap-around: ptr=3 with req3 and req0 active → W0=3 on port A, W1=0 on port B, new ptr=1.
- Reset mid-read: assert rst in the cycle after granting req2's read → no rvalid[2] after release, and all outputs are at reset values.
